// File: rtl/soc_mem_responder.sv
// soc_mem_responder: byte-writable RAM plus an IO page (LED register, 8N1 UART transmitter) on the CPU memory bus.
module soc_mem_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter     INIT_FILE    = "",
    parameter int CLKS_PER_BIT = 868
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    sh, sh_n;
    logic          ovf, ovf_n;
    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          io, busy, tc, uart_wr, status_rd;
    logic [31:0]   io_rd;
    logic          unused;

    assign io        = mem_addr[22];
    assign idx       = mem_addr[AW+1:2];
    assign off       = mem_addr[3:2];
    assign busy      = state != IDLE;
    assign tc        = cnt == CW'(CLKS_PER_BIT - 1);
    assign uart_wr   = io && off == 2'd1 && mem_wstrb[0];
    assign status_rd = io && off == 2'd2 && mem_rstrb;
    assign io_rd     = off == 2'd0 ? {24'b0, leds} : off == 2'd2 ? {30'b0, ovf, busy} : 32'b0;
    assign uart_tx   = state == START ? 1'b0 : state == DATA ? sh[bit_idx] : 1'b1;
    assign unused    = &{1'b0, mem_addr[31:23], mem_addr[21:AW+2], mem_addr[1:0]};

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (!io && mem_wstrb[i]) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];

    // A dropped write sets overflow even if a status read clears it in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = tc ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        ovf_n   = (uart_wr && busy) || (ovf && !status_rd);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (uart_wr) begin
                    sh_n    = mem_wdata[7:0];
                    bit_n   = 3'd0;
                    state_n = START;
                end
            end
            START: if (tc) state_n = DATA;
            DATA: if (tc) begin
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            STOP: if (tc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            sh        <= 8'd0;
            ovf       <= 1'b0;
            leds      <= 8'd0;
            mem_rdata <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            ovf     <= ovf_n;
            if (io && off == 2'd0 && mem_wstrb[0]) leds <= mem_wdata[7:0];
            if (mem_rstrb) mem_rdata <= io ? io_rd : ram[idx];
        end
    end
endmodule

// File: tb/tb_soc_mem_responder.sv
// tb_soc_mem_responder: directed checks of RAM, LED, UART framing, overflow and mid-frame reset.
module tb_soc_mem_responder;
    localparam logic [31:0] IO_LEDS = 32'h0040_0000;
    localparam logic [31:0] IO_DATA = 32'h0040_0004;
    localparam logic [31:0] IO_STAT = 32'h0040_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic [7:0]  leds;
    logic        uart_tx;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] r;
    logic [9:0]  fr;

    soc_mem_responder #(.MEM_WORDS(1024), .INIT_FILE(""), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .leds(leds), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_wstrb = 4'b0;
        mem_rstrb = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_rstrb = 1'b0;
        tick();
        idle_in();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a; mem_wstrb = 4'b0; mem_rstrb = 1'b1;
        tick();
        idle_in();
        d = mem_rdata;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_leds", {24'b0, leds}, 32'h0);
        chk("reset_tx", {31'b0, uart_tx}, 32'h1);
        rd(IO_STAT, r); chk("reset_status", r, 32'h0);

        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        rd(32'h10, r); chk("ram_full", r, 32'hDEADBEEF);
        wr(32'h10, 32'h00AA00AA, 4'b0100);
        rd(32'h10, r); chk("ram_lane2", r, 32'hDEAABEEF);

        wr(32'h1000, 32'h12345678, 4'b1111);
        rd(32'h0, r); chk("alias", r, 32'h12345678);
        mem_addr = 32'h0; mem_wdata = 32'hFFFFFFFF; mem_wstrb = 4'b1111; mem_rstrb = 1'b1;
        tick();
        idle_in();
        chk("rbw_old", mem_rdata, 32'h12345678);
        rd(32'h0, r); chk("rbw_new", r, 32'hFFFFFFFF);

        wr(IO_LEDS, 32'h0000005A, 4'b0001);
        chk("leds_set", {24'b0, leds}, 32'h5A);
        rd(IO_LEDS, r); chk("leds_read", r, 32'h5A);
        mem_addr = 32'h10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rdata_hold", mem_rdata, 32'h5A);
        end

        // 0xA5 frame; status is polled every cycle through the read port
        wr(IO_DATA, 32'hA5, 4'b0001);
        fr = {1'b1, 8'hA5, 1'b0};
        mem_addr = IO_STAT; mem_rstrb = 1'b1;
        for (int k = 0; k < 40; k++) begin
            chk("tx_a5", {31'b0, uart_tx}, {31'b0, fr[k/4]});
            if (k > 0) chk("busy_a5", mem_rdata, 32'h1);
            tick();
        end
        idle_in();
        chk("busy_stop_edge", mem_rdata, 32'h1);
        rd(IO_STAT, r); chk("idle_after_a5", r, 32'h0);

        wr(IO_DATA, 32'h41, 4'b0001);
        fr = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 40; k++) begin
            chk("tx_41", {31'b0, uart_tx}, {31'b0, fr[k/4]});
            if (k == 4) chk("ovf_status", mem_rdata, 32'h3);
            if (k == 6) chk("ovf_cleared", mem_rdata, 32'h1);
            idle_in();
            if (k == 1 || k == 39) begin
                mem_addr = IO_DATA; mem_wdata = (k == 1) ? 32'h42 : 32'h43; mem_wstrb = 4'b0001;
            end
            if (k == 3 || k == 5) begin
                mem_addr = IO_STAT; mem_rstrb = 1'b1;
            end
            tick();
        end
        idle_in();
        chk("tx_idle_after_41", {31'b0, uart_tx}, 32'h1);
        wr(IO_DATA, 32'h44, 4'b0001);
        chk("tx_start_44", {31'b0, uart_tx}, 32'h0);
        rd(IO_STAT, r); chk("edge_drop_ovf", r, 32'h3);

        // now inside data bit 3 of the 0x44 frame
        repeat (15) tick();
        chk("tx_bit3_44", {31'b0, uart_tx}, 32'h0);
        wr(IO_LEDS, 32'h77, 4'b0001);
        rd(IO_LEDS, r); chk("leds_pre_rst", r, 32'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_tx", {31'b0, uart_tx}, 32'h1);
        chk("rst_leds", {24'b0, leds}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        rd(IO_STAT, r); chk("rst_status", r, 32'h0);

        wr(IO_DATA, 32'h3C, 4'b0001);
        fr = {1'b1, 8'h3C, 1'b0};
        for (int k = 0; k < 40; k++) begin
            chk("tx_3c", {31'b0, uart_tx}, {31'b0, fr[k/4]});
            tick();
        end
        rd(IO_STAT, r); chk("idle_after_3c", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
